shift_sequencer: RTL and testbench

Multi-cycle shift unit controller for the processor's execute stage. Accepts one 32-bit shift operation (SLL or SRA) through a valid/ready handshake. It sequences it through the power-of-two shift stages (16, 8, 4, 2, 1), applying one stage per cycle against an internal working register. It then presents the result on a held valid/ready output, replacing a single-cycle barrel shifter on the critical path.

---
 rtl/shift_sequencer.sv | 150 +++++++++++++++
 tb/tb_shift_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit shift unit (SLL / SRA) for the execute stage.
// Applies one power-of-two stage (16, 8, 4, 2, 1) per cycle to a working register.
// Build option: define SHIFT_SEQ_EARLY_DONE_EN to leave SHIFT as soon as the
// remaining lower shamt bits are all zero (variable latency); otherwise every
// operation takes the full five stages.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an operation, in_ready high (out of reset)
// SHIFT | applying stage 2^step_q to the working register
// DONE  | result held on out_data with out_valid high until out_ready
module shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       op,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [WIDTH-1:0]           work_q, work_d;
  logic [$clog2(WIDTH)-1:0]   shamt_q, shamt_d;
  logic                       op_q, op_d;
  logic [2:0]                 step_q, step_d;

  logic [WIDTH-1:0]           stage_sll;
  logic [WIDTH-1:0]           stage_sra;
  logic                       last_step;

  // Fixed-distance shift for the current stage; a mux of five constant shifts
  // rather than a full barrel shifter.
  always_comb begin
    stage_sll = work_q;
    stage_sra = work_q;
    case (step_q)
      3'd4: begin
        stage_sll = work_q << 16;
        stage_sra = $signed(work_q) >>> 16;
      end
      3'd3: begin
        stage_sll = work_q << 8;
        stage_sra = $signed(work_q) >>> 8;
      end
      3'd2: begin
        stage_sll = work_q << 4;
        stage_sra = $signed(work_q) >>> 4;
      end
      3'd1: begin
        stage_sll = work_q << 2;
        stage_sra = $signed(work_q) >>> 2;
      end
      default: begin
        stage_sll = work_q << 1;
        stage_sra = $signed(work_q) >>> 1;
      end
    endcase
  end

`ifdef SHIFT_SEQ_EARLY_DONE_EN
  logic [$clog2(WIDTH)-1:0] low_mask;

  // Leave SHIFT once no lower stage would change the working value.
  always_comb begin
    low_mask  = ($clog2(WIDTH))'(1) << step_q;
    low_mask  = low_mask - ($clog2(WIDTH))'(1);
    last_step = (step_q == 3'd0) || ((shamt_q & low_mask) == '0);
  end
`else
  // Fixed latency: always run all stages down to step 0.
  always_comb begin
    last_step = (step_q == 3'd0);
  end
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          shamt_d = shamt;
          op_d    = op;
          step_d  = 3'd4;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shamt_q[step_q]) begin
          work_d = op_q ? stage_sra : stage_sll;
        end
        if (last_step) begin
          state_d = DONE;
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      shamt_q <= '0;
      op_q    <= 1'b0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      step_q  <= step_d;
    end
  end

  // in_ready is gated by reset_n so it stays low while reset is asserted.
  assign in_ready  = (state_q == IDLE) && reset_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases, reset
// mid-operation, backpressure, and 1000 random operations against an
// arithmetic reference model. Latency expectations follow the build macro.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  shift_sequencer #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_in   (data_in),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic o, input logic [31:0] d, input logic [4:0] s);
    if (o) return 32'($signed(d) >>> s);
    return d << s;
  endfunction

  function automatic int model_lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
    if (s == 5'd0) return 1;
    for (int i = 0; i < 5; i++) begin
      if (s[i]) return 5 - i;
    end
    return 1;
`else
    return 5;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Waits for out_valid after the handshake edge; returns edges counted (0 on timeout).
  task automatic wait_out_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic o, input logic [31:0] d, input logic [4:0] s, input int hold);
    int lat;
    logic [31:0] exp;
    exp = model_res(o, d, s);
    wait_in_ready();
    op = o; data_in = d; shamt = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    data_in = ~d;
    chk("busy_after_hs", 32'(busy), 32'd1);
    wait_out_valid(lat);
    chk("latency", 32'(lat), 32'(model_lat(s)));
    chk("result", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, exp);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_accept", 32'(busy), 32'd0);
    chk("valid_after_accept", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] exp_a, exp_b;

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed corner cases
    run_op(1'b1, 32'h8000_0000, 5'd16, 0);
    run_op(1'b0, 32'h0000_0001, 5'd31, 0);
    run_op(1'b1, 32'h7FFF_FFFF, 5'd31, 0);
    run_op(1'b1, 32'h8000_0001, 5'd31, 0);
    run_op(1'b1, 32'hDEAD_BEEF, 5'd0, 0);
    run_op(1'b0, 32'hDEAD_BEEF, 5'd0, 1);
    run_op(1'b0, 32'hA5A5_A5A5, 5'd1, 0);
    run_op(1'b1, 32'hF000_1234, 5'd4, 2);
    run_op(1'b0, 32'h1234_5678, 5'd24, 0);

    // Reset mid-operation
    wait_in_ready();
    op = 1'b1; data_in = 32'h8000_0000; shamt = 5'd16; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end

    // Backpressure with in_valid held high throughout
    exp_a = model_res(1'b0, 32'h0000_0003, 5'd8);
    exp_b = model_res(1'b1, 32'h9234_5678, 5'd4);
    wait_in_ready();
    op = 1'b0; data_in = 32'h0000_0003; shamt = 5'd8; in_valid = 1'b1;
    tick();
    op = 1'b1; data_in = 32'h9234_5678; shamt = 5'd4;
    wait_out_valid(lat);
    chk("bp_latency", 32'(lat), 32'(model_lat(5'd8)));
    chk("bp_result", out_data, exp_a);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("bp_hold_data", out_data, exp_a);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_capture", 32'(busy), 32'd1);
    wait_out_valid(lat);
    chk("bp2_latency", 32'(lat), 32'(model_lat(5'd4)));
    chk("bp2_result", out_data, exp_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      run_op(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
             ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
